// File: rtl/data_converter.sv
// -----------------------------------------------------------------------------
// data_converter
//   Serial-to-parallel byte deframer. Looks for UART-style frames on a
//   one-bit-per-clock serial line: idle high, one start bit (0), eight data
//   bits, one stop bit (1). Each accepted byte is presented in parallel,
//   together with the byte before it and a running XOR checksum.
//
// Ports
//   CLK_30MHZ  in   1  sole clock, rising edge; DIN carries one bit per cycle
//   RST        in   1  asynchronous, active-low reset
//   DIN        in   1  serial data, idle high
//   MODE       in   1  bit order, latched at the start bit:
//                      1 = MSB-first, 0 = LSB-first
//   DOUT_A     out  8  most recently accepted byte
//   DOUT_B     out  8  byte accepted before DOUT_A
//   DOUT_C     out  8  XOR of all bytes accepted since reset
//   CLK_OUT    out  1  toggles once per accepted byte
//   VALID      out  1  one-cycle pulse in the cycle after DOUT_A/B/C update
//
// Build option
//   DATACONV_STOP_CHECK_EN  when defined, a 0 stop bit is a framing error:
//                           the byte is dropped and the deframer re-arms,
//                           waiting for a 1 before the next start bit.
//                           When undefined, the stop bit is not checked.
// -----------------------------------------------------------------------------
module data_converter (
    input  logic       CLK_30MHZ,
    input  logic       RST,
    input  logic       DIN,
    input  logic       MODE,
    output logic [7:0] DOUT_A,
    output logic [7:0] DOUT_B,
    output logic [7:0] DOUT_C,
    output logic       CLK_OUT,
    output logic       VALID
);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_accept;
    logic       w_start;

    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_mode;
    logic [7:0] r_dout_a;
    logic [7:0] r_dout_b;
    logic [7:0] r_dout_c;
    logic       r_clk_out;
    logic       r_valid;

    // A start bit is only recognised from IDLE; ARM swallows a low or
    // unknown line after reset (or after a framing error).
    assign w_start = (r_state == IDLE) && !DIN;

    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            r_state <= ARM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ARM: begin
                if (DIN) w_next_state = IDLE;
            end
            IDLE: begin
                if (!DIN) w_next_state = DATA;
            end
            DATA: begin
                if (r_cnt == 3'd7) w_next_state = STOP;
            end
            STOP: begin
`ifdef DATACONV_STOP_CHECK_EN
                if (DIN) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = ARM;
                end
`else
                w_accept     = 1'b1;
                w_next_state = IDLE;
`endif
            end
            default: w_next_state = ARM;
        endcase
    end

    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            r_cnt     <= 3'd0;
            r_shift   <= 8'h00;
            r_mode    <= 1'b0;
            r_dout_a  <= 8'h00;
            r_dout_b  <= 8'h00;
            r_dout_c  <= 8'h00;
            r_clk_out <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            // Bit order is frozen for the whole frame at the start bit.
            if (w_start) begin
                r_mode <= MODE;
                r_cnt  <= 3'd0;
            end

            // Counter wraps 7 -> 0 on the last data bit.
            if (r_state == DATA) begin
                r_cnt <= r_cnt + 3'd1;
                if (r_mode) begin
                    r_shift <= {r_shift[6:0], DIN};
                end else begin
                    r_shift <= {DIN, r_shift[7:1]};
                end
            end

            if (w_accept) begin
                r_dout_b  <= r_dout_a;
                r_dout_a  <= r_shift;
                r_dout_c  <= r_dout_c ^ r_shift;
                r_clk_out <= ~r_clk_out;
            end

            r_valid <= w_accept;
        end
    end

    assign DOUT_A  = r_dout_a;
    assign DOUT_B  = r_dout_b;
    assign DOUT_C  = r_dout_c;
    assign CLK_OUT = r_clk_out;
    assign VALID   = r_valid;

endmodule

// File: tb/tb_data_converter.sv
module tb_data_converter;

    logic       CLK_30MHZ;
    logic       RST;
    logic       DIN;
    logic       MODE;
    logic [7:0] DOUT_A;
    logic [7:0] DOUT_B;
    logic [7:0] DOUT_C;
    logic       CLK_OUT;
    logic       VALID;

    int n_pass;
    int n_total;
    int cyc;
    int n_valid;
    int last_valid_cyc;
    int prev_valid_cyc;
    int start_cyc;
    int v0;

    data_converter dut (
        .CLK_30MHZ (CLK_30MHZ),
        .RST       (RST),
        .DIN       (DIN),
        .MODE      (MODE),
        .DOUT_A    (DOUT_A),
        .DOUT_B    (DOUT_B),
        .DOUT_C    (DOUT_C),
        .CLK_OUT   (CLK_OUT),
        .VALID     (VALID)
    );

    initial CLK_30MHZ = 1'b0;
    always #5 CLK_30MHZ = ~CLK_30MHZ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one serial bit, let the edge happen, sample 1 time unit later.
    task automatic tick(input logic b);
        DIN = b;
        @(posedge CLK_30MHZ);
        #1;
        cyc++;
        if (VALID) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
    endtask

    // seq[7] goes on the line first. MODE is flipped during the data bits
    // to confirm the frame keeps the order latched at its start bit.
    task automatic send_frame(input logic mode, input logic [7:0] seq, input logic stop);
        MODE = mode;
        tick(1'b0);
        start_cyc = cyc;
        MODE = ~mode;
        for (int i = 7; i >= 0; i--) tick(seq[i]);
        tick(stop);
        MODE = mode;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; n_valid = 0;
        last_valid_cyc = 0; prev_valid_cyc = 0; start_cyc = 0;
        RST = 1'b0; DIN = 1'b0; MODE = 1'b1;

        // Reset held with DIN toggling
        for (int i = 0; i < 6; i++) tick(i[0]);
        chk("rst_dout_a", {24'd0, DOUT_A}, 32'h00);
        chk("rst_dout_b", {24'd0, DOUT_B}, 32'h00);
        chk("rst_dout_c", {24'd0, DOUT_C}, 32'h00);
        chk("rst_clk_out", {31'd0, CLK_OUT}, 32'd0);
        chk("rst_no_valid", n_valid, 0);

        // Released with the line held low: nothing may be framed
        RST = 1'b1;
        for (int i = 0; i < 14; i++) tick(1'b0);
        chk("arm_low_no_valid", n_valid, 0);
        chk("arm_low_dout_a", {24'd0, DOUT_A}, 32'h00);

        // MODE=1 stream, back-to-back frames
        for (int i = 0; i < 11; i++) tick(1'b1);
        send_frame(1'b1, 8'b10001001, 1'b1);
        chk("m1_f1_valid", {31'd0, VALID}, 32'd1);
        chk("m1_f1_latency", last_valid_cyc - start_cyc, 9);
        chk("m1_f1_dout_a", {24'd0, DOUT_A}, 32'h89);
        chk("m1_f1_dout_c", {24'd0, DOUT_C}, 32'h89);
        chk("m1_f1_clk_out", {31'd0, CLK_OUT}, 32'd1);
        send_frame(1'b1, 8'b11010101, 1'b1);
        chk("m1_f2_dout_a", {24'd0, DOUT_A}, 32'hD5);
        chk("m1_f2_dout_b", {24'd0, DOUT_B}, 32'h89);
        chk("m1_f2_dout_c", {24'd0, DOUT_C}, 32'h5C);
        chk("m1_f2_latency", last_valid_cyc - start_cyc, 9);
        chk("b2b_spacing", last_valid_cyc - prev_valid_cyc, 10);
        chk("m1_clk_out_back", {31'd0, CLK_OUT}, 32'd0);
        tick(1'b1);
        chk("m1_valid_one_cycle", {31'd0, VALID}, 32'd0);
        tick(1'b1);
        chk("m1_valid_count", n_valid, 2);

        // Asynchronous reset, then MODE=0 stream
        RST = 1'b0;
        #1;
        chk("async_rst_dout_c", {24'd0, DOUT_C}, 32'h00);
        chk("async_rst_dout_a", {24'd0, DOUT_A}, 32'h00);
        tick(1'b1);
        RST = 1'b1;
        for (int i = 0; i < 11; i++) tick(1'b1);
        v0 = n_valid;
        send_frame(1'b0, 8'b10001001, 1'b1);
        chk("m0_f1_dout_a", {24'd0, DOUT_A}, 32'h91);
        send_frame(1'b0, 8'b11010101, 1'b1);
        chk("m0_f2_dout_a", {24'd0, DOUT_A}, 32'hAB);
        chk("m0_f2_dout_b", {24'd0, DOUT_B}, 32'h91);
        chk("m0_f2_dout_c", {24'd0, DOUT_C}, 32'h3A);
        chk("m0_valid_count", n_valid - v0, 2);

        // Stop bit of 0
        v0 = n_valid;
        send_frame(1'b1, 8'h0F, 1'b0);
`ifdef DATACONV_STOP_CHECK_EN
        chk("stop0_dout_a", {24'd0, DOUT_A}, 32'hAB);
        chk("stop0_dout_c", {24'd0, DOUT_C}, 32'h3A);
        chk("stop0_no_valid", n_valid - v0, 0);
        for (int i = 0; i < 12; i++) tick(1'b0);
        chk("stop0_rearm_no_valid", n_valid - v0, 0);
        tick(1'b1);
        send_frame(1'b1, 8'h3C, 1'b1);
        chk("stop0_next_dout_a", {24'd0, DOUT_A}, 32'h3C);
        chk("stop0_next_dout_c", {24'd0, DOUT_C}, 32'h06);
`else
        chk("stop0_dout_a", {24'd0, DOUT_A}, 32'h0F);
        chk("stop0_dout_b", {24'd0, DOUT_B}, 32'hAB);
        chk("stop0_dout_c", {24'd0, DOUT_C}, 32'h35);
        chk("stop0_valid", n_valid - v0, 1);
        tick(1'b1);
        send_frame(1'b1, 8'h3C, 1'b1);
        chk("stop0_next_dout_a", {24'd0, DOUT_A}, 32'h3C);
        chk("stop0_next_dout_c", {24'd0, DOUT_C}, 32'h09);
`endif

        // Reset at the 4th data bit
        tick(1'b1);
        MODE = 1'b1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        DIN = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        chk("midrst_dout_a", {24'd0, DOUT_A}, 32'h00);
        chk("midrst_dout_c", {24'd0, DOUT_C}, 32'h00);
        chk("midrst_clk_out", {31'd0, CLK_OUT}, 32'd0);
        tick(1'b0);
        tick(1'b1);
        RST = 1'b1;
        tick(1'b1);
        tick(1'b1);
        send_frame(1'b1, 8'hA5, 1'b1);
        chk("post_rst_valid", {31'd0, VALID}, 32'd1);
        chk("post_rst_dout_a", {24'd0, DOUT_A}, 32'hA5);
        chk("post_rst_dout_b", {24'd0, DOUT_B}, 32'h00);
        chk("post_rst_dout_c", {24'd0, DOUT_C}, 32'hA5);
        chk("post_rst_clk_out", {31'd0, CLK_OUT}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_converter.md
# data_converter

Serial-to-parallel byte deframer for the front end of the data path. Hunts for UART-style frames on a one-bit-per-clock serial line (idle high, start 0, 8 data bits, stop 1) and presents each byte in parallel. Outputs: the latest byte, the previous byte and a running XOR checksum, with a valid strobe and a byte-rate toggle clock for downstream logic.

## Interface
- No parameters; frame format fixed at 1 start, 8 data, 1 stop bit.
- CLK_30MHZ  in  1  sole clock, all logic on rising edge; DIN carries one bit per cycle.
- RST  in  1  asynchronous, active-low reset.
- DIN  in  1  serial data, idle high.
- MODE  in  1  bit order: 1 = MSB-first (first data bit → bit 7), 0 = LSB-first (first data bit → bit 0).
- DOUT_A  out  8  most recently accepted byte.
- DOUT_B  out  8  byte accepted before DOUT_A.
- DOUT_C  out  8  running XOR of all accepted bytes since reset.
- CLK_OUT  out  1  toggles once per accepted byte.
- VALID  out  1  one-cycle pulse when DOUT_A/B/C update.

## Operation
- FSM states: ARM, IDLE, DATA, STOP.
- ARM (reset state): wait for DIN=1 → IDLE. Blocks false starts from a low or unknown line after reset.
- IDLE: DIN=0 → DATA. Latch MODE for the frame; clear bit counter.
- DATA: shift DIN into the byte per the latched MODE, one bit per cycle. After the 8th bit → STOP.
- STOP, DIN=1: accept the byte, → IDLE.
- STOP, DIN=0: handling per Configuration.
- Accept action, all in one edge:
  - DOUT_B ← DOUT_A, DOUT_A ← byte, DOUT_C ← DOUT_C ^ byte.
  - CLK_OUT inverts; VALID = 1 for exactly the next cycle.
- MODE changes mid-frame do not affect the frame in progress.
- Back-to-back frames: a start bit on the cycle right after the stop is detected (no idle gap required).
- Reset values: DOUT_A = DOUT_B = DOUT_C = 0x00, CLK_OUT = 0, VALID = 0, state ARM, counter 0, shift register 0.
- Reset mid-frame: partial byte discarded; all outputs return to reset values immediately (asynchronously).

## Timing
- Start bit sampled at edge N; data bits at edges N+1..N+8; stop bit at edge N+9.
- Outputs change at edge N+9; VALID high from N+9 to N+10.
- Minimum frame period: 10 cycles. Byte throughput: 1 byte per 10 cycles.
- CLK_OUT period: 2 accepted bytes.

## Configuration
- Macro: DATACONV_STOP_CHECK_EN.
- Defined: stop bit = 0 is a framing error.
  - Byte discarded; no output change, no VALID, no CLK_OUT toggle.
  - FSM → ARM (a 1 is needed before the next start).
- Undefined: stop bit is not checked; every frame is accepted at the STOP cycle and the FSM → IDLE.

## Test plan
- Reset/hold: RST=0 with DIN toggling → all outputs 0, no VALID. RST=1 with DIN held 0 → nothing accepted until DIN goes 1.
- MODE=1 stream: 11 idle ones, then 0,10001001,1 then 0,11010101,1:
  - First frame: DOUT_A=0x89, DOUT_C=0x89.
  - Second frame: DOUT_A=0xD5, DOUT_B=0x89, DOUT_C=0x5C.
  - Exactly 2 VALID pulses, 9 cycles after each start bit; CLK_OUT back to 0.
- MODE=0, same stream → 0x91 then 0xAB; DOUT_B=0x91, DOUT_C=0x3A.
- Back-to-back frames with no idle gap: each frame accepted, VALID pulses 10 cycles apart.
- Stop bit 0 with DATACONV_STOP_CHECK_EN defined: outputs unchanged, no VALID, next valid frame accepted only after a 1. Same stimulus without the macro: byte accepted.
- Reset asserted at the 4th data bit: outputs clear at once. After release, a complete frame decodes correctly, with DOUT_C equal to that byte alone.
